// File: rtl/timer_tick_scheduler_if.sv
// Avalon-MM bus between the tick scheduler (master) and the interval timer slave.
// The timer has no waitrequest and only a level interrupt back to the master.
interface timer_tick_scheduler_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input irq);
  modport slave  (input address, chipselect, write_n, writedata, output irq);
endinterface

// File: rtl/timer_tick_scheduler.sv
// Programs the interval timer, services its interrupt, keeps a tick count and
// runs a bank of software timeout channels that decrement once per serviced tick.
module timer_tick_scheduler #(
  parameter logic [31:0] PERIOD_DEFAULT = 32'd1499,
  parameter int          NUM_CH         = 4,
  parameter int          CH_W           = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  input  logic [31:0]         cfg_period,
  output logic                cfg_busy,
  timer_tick_scheduler_if.master tmr,
  output logic                tick_pulse,
  output logic [31:0]         tick_count,
  input  logic [NUM_CH-1:0]   ch_load,
  input  logic [CH_W-1:0]     ch_value,
  input  logic [NUM_CH-1:0]   ch_cancel,
  output logic [NUM_CH-1:0]   ch_active,
  output logic [NUM_CH-1:0]   ch_expire
);

  typedef enum logic [2:0] {PL, PH, CLR, CTRL, RUN, ACK, STOP} state_t;

  localparam logic [CH_W-1:0] CH_ONE = {{(CH_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [31:0]       period;
  logic [31:0]       pend_period;
  logic              pending;
  logic              tick;
  logic [CH_W-1:0]   ch_count [NUM_CH];

  assign tick = (state == ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PL;
    else          state <= state_next;
  end

  // An interrupt is always serviced before a pending reprogramming sequence starts.
  always_comb begin
    state_next = state;
    case (state)
      PL:      state_next = PH;
      PH:      state_next = CLR;
      CLR:     state_next = CTRL;
      CTRL:    state_next = RUN;
      RUN: begin
        if (tmr.irq)      state_next = ACK;
        else if (pending) state_next = STOP;
      end
      ACK:     state_next = RUN;
      STOP:    state_next = PL;
      default: state_next = PL;
    endcase
  end

  // Every state except RUN is a single-cycle write; the bus stays idle while in reset.
  always_comb begin
    tmr.address    = 3'd0;
    tmr.writedata  = 16'h0000;
    tmr.chipselect = 1'b0;
    tmr.write_n    = 1'b1;
    if (reset_n) begin
      case (state)
        PL:   begin tmr.address = 3'd2; tmr.writedata = period[15:0];  end
        PH:   begin tmr.address = 3'd3; tmr.writedata = period[31:16]; end
        CLR:  begin tmr.address = 3'd0; tmr.writedata = 16'h0000;      end
        CTRL: begin tmr.address = 3'd1; tmr.writedata = 16'h0007;      end
        ACK:  begin tmr.address = 3'd0; tmr.writedata = 16'h0000;      end
        STOP: begin tmr.address = 3'd1; tmr.writedata = 16'h0008;      end
        default: ;
      endcase
      tmr.chipselect = (state != RUN);
      tmr.write_n    = (state == RUN);
    end
  end

  // A request landing while the previous one is being applied leaves pending set,
  // so a further complete sequence follows with the newest value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period      <= PERIOD_DEFAULT;
      pend_period <= PERIOD_DEFAULT;
      pending     <= 1'b0;
      cfg_busy    <= 1'b1;
    end else begin
      if (state == STOP) begin
        period  <= pend_period;
        pending <= 1'b0;
      end
      if (state_next == RUN && state != RUN && !pending)
        cfg_busy <= 1'b0;
      if (cfg_valid) begin
        pend_period <= cfg_period;
        pending     <= 1'b1;
        cfg_busy    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_pulse <= 1'b0;
      tick_count <= 32'd0;
    end else begin
      tick_pulse <= tick;
      if (tick) tick_count <= tick_count + 32'd1;
    end
  end

  // Cancel outranks load, and load outranks a same-cycle tick decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_active <= '0;
      ch_expire <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_count[i] <= '0;
    end else begin
      ch_expire <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_cancel[i]) begin
          ch_active[i] <= 1'b0;
        end else if (ch_load[i]) begin
          if (ch_value != '0) begin
            ch_count[i]  <= ch_value;
            ch_active[i] <= 1'b1;
          end else begin
            ch_active[i] <= 1'b0;
          end
        end else if (tick && ch_active[i]) begin
          ch_count[i] <= ch_count[i] - CH_ONE;
          if (ch_count[i] == CH_ONE) begin
            ch_active[i] <= 1'b0;
            ch_expire[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: a transaction-queue model of the bus writes plus
// tick/channel bookkeeping is compared against the DUT on every falling edge.
module tb_timer_tick_scheduler;

  localparam int          NUM_CH         = 4;
  localparam int          CH_W           = 16;
  localparam logic [31:0] PERIOD_DEFAULT = 32'd1499;

  localparam int T_STOP = 0, T_PL = 1, T_PH = 2, T_CLR = 3, T_CTRL = 4, T_ACK = 5;

  localparam logic [18:0] SEQ_RESET [4] = '{19'h205DB, 19'h30000, 19'h00000, 19'h10007};
  localparam logic [18:0] SEQ_CFG   [5] = '{19'h10008, 19'h286A0, 19'h30001, 19'h00000, 19'h10007};
  localparam logic [18:0] SEQ_BOTH  [6] = '{19'h00000, 19'h10008, 19'h205DB, 19'h30000,
                                            19'h00000, 19'h10007};

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_valid;
  logic [31:0]       cfg_period;
  logic              cfg_busy;
  logic              tick_pulse;
  logic [31:0]       tick_count;
  logic [NUM_CH-1:0] ch_load;
  logic [CH_W-1:0]   ch_value;
  logic [NUM_CH-1:0] ch_cancel;
  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] ch_expire;

  timer_tick_scheduler_if tmr_bus ();

  timer_tick_scheduler #(
    .PERIOD_DEFAULT(PERIOD_DEFAULT),
    .NUM_CH(NUM_CH),
    .CH_W(CH_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_valid(cfg_valid),
    .cfg_period(cfg_period),
    .cfg_busy(cfg_busy),
    .tmr(tmr_bus),
    .tick_pulse(tick_pulse),
    .tick_count(tick_count),
    .ch_load(ch_load),
    .ch_value(ch_value),
    .ch_cancel(ch_cancel),
    .ch_active(ch_active),
    .ch_expire(ch_expire)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int                q[$];
  logic [31:0]       m_period, m_pend, m_count;
  bit                m_pending, m_busy, m_tick;
  int                m_rem [NUM_CH];
  logic [NUM_CH-1:0] m_act, m_exp;
  bit                irq_req, prev_wrote0;

  logic [2:0]  col_a [8];
  logic [15:0] col_d [8];
  int          col_n;

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tagWrite(input int tag, output logic [2:0] a, output logic [15:0] d);
    case (tag)
      T_STOP:  begin a = 3'd1; d = 16'h0008; end
      T_PL:    begin a = 3'd2; d = m_period[15:0]; end
      T_PH:    begin a = 3'd3; d = m_period[31:16]; end
      T_CTRL:  begin a = 3'd1; d = 16'h0007; end
      default: begin a = 3'd0; d = 16'h0000; end
    endcase
  endtask

  task automatic modelReset();
    q = {T_PL, T_PH, T_CLR, T_CTRL};
    m_period  = PERIOD_DEFAULT;
    m_pend    = PERIOD_DEFAULT;
    m_pending = 0;
    m_busy    = 1;
    m_tick    = 0;
    m_count   = 32'd0;
    m_act     = '0;
    m_exp     = '0;
    for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
  endtask

  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic modelStep();
    bit tick;
    bit enter_run;
    int t;
    tick = 0;
    enter_run = 0;
    if (q.size() == 0) begin
      if (tmr_bus.irq)    q.push_back(T_ACK);
      else if (m_pending) q = {T_STOP, T_PL, T_PH, T_CLR, T_CTRL};
    end else begin
      t = q.pop_front();
      if (t == T_STOP) begin
        m_period  = m_pend;
        m_pending = 0;
      end
      if (t == T_ACK) tick = 1;
      if (q.size() == 0) enter_run = 1;
    end
    if (enter_run && !m_pending) m_busy = 0;
    if (cfg_valid) begin
      m_pend    = cfg_period;
      m_pending = 1;
      m_busy    = 1;
    end
    m_tick = tick;
    if (tick) m_count = m_count + 32'd1;
    m_exp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_cancel[i]) m_act[i] = 1'b0;
      else if (ch_load[i]) begin
        if (ch_value != '0) begin
          m_rem[i] = int'(ch_value);
          m_act[i] = 1'b1;
        end else m_act[i] = 1'b0;
      end else if (tick && m_act[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_act[i] = 1'b0;
          m_exp[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [2:0]  a;
    logic [15:0] d;
    if (!reset_n) begin
      cmp("rst_cs",   tmr_bus.chipselect, 0);
      cmp("rst_wn",   tmr_bus.write_n,    1);
      cmp("rst_addr", tmr_bus.address,    0);
      cmp("rst_data", tmr_bus.writedata,  0);
    end else if (q.size() > 0) begin
      tagWrite(q[0], a, d);
      cmp("bus_cs",   tmr_bus.chipselect, 1);
      cmp("bus_wn",   tmr_bus.write_n,    0);
      cmp("bus_addr", tmr_bus.address,    a);
      cmp("bus_data", tmr_bus.writedata,  d);
    end else begin
      cmp("idle_cs", tmr_bus.chipselect, 0);
      cmp("idle_wn", tmr_bus.write_n,    1);
    end
    cmp("cfg_busy",   cfg_busy,   m_busy);
    cmp("tick_pulse", tick_pulse, m_tick);
    cmp("tick_count", tick_count, m_count);
    cmp("ch_active",  ch_active,  m_act);
    cmp("ch_expire",  ch_expire,  m_exp);
  endtask

  // Compare process; also plays the timer slave, whose irq drops after a write to address 0.
  always @(negedge clk) begin
    if (!reset_n) begin
      modelReset();
      tmr_bus.irq = 1'b0;
      prev_wrote0 = 0;
      irq_req     = 0;
      checkOutput();
    end else begin
      checkOutput();
      if (prev_wrote0) tmr_bus.irq = 1'b0;
      if (irq_req) begin
        tmr_bus.irq = 1'b1;
        irq_req     = 0;
      end
      prev_wrote0 = tmr_bus.chipselect && !tmr_bus.write_n && (tmr_bus.address == 3'd0);
      modelStep();
    end
  end

  task automatic applyStimulus(input bit cv, input logic [31:0] cp, input logic [NUM_CH-1:0] ld,
                               input logic [NUM_CH-1:0] cn, input logic [CH_W-1:0] val, input bit ir);
    @(posedge clk);
    #1;
    cfg_valid  = cv;
    cfg_period = cp;
    ch_load    = ld;
    ch_cancel  = cn;
    ch_value   = val;
    if (ir) irq_req = 1;
  endtask

  task automatic doTick(output logic [NUM_CH-1:0] exp_v, output logic [NUM_CH-1:0] act_v);
    bit seen;
    seen  = 0;
    exp_v = '0;
    act_v = '0;
    applyStimulus(0, 32'd0, '0, '0, '0, 1);
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (tick_pulse) begin
        seen  = 1;
        exp_v = ch_expire;
        act_v = ch_active;
      end
    end
    cmp("tick_seen", seen, 1);
  endtask

  task automatic collectWrites(input int want);
    col_n = 0;
    for (int c = 0; c < 40 && col_n < want; c++) begin
      @(negedge clk);
      cmp("busy_in_seq", cfg_busy, 1);
      if (tmr_bus.chipselect && !tmr_bus.write_n) begin
        col_a[col_n] = tmr_bus.address;
        col_d[col_n] = tmr_bus.writedata;
        col_n++;
      end
    end
    cmp("seq_len", col_n, want);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] ev, av;
    reset_n     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_period  = 32'd0;
    ch_load     = '0;
    ch_cancel   = '0;
    ch_value    = '0;
    tmr_bus.irq = 1'b0;
    irq_req     = 0;
    prev_wrote0 = 0;
    modelReset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("lit_rst_cs",    tmr_bus.chipselect, 0);
    cmp("lit_rst_busy",  cfg_busy, 1);
    cmp("lit_rst_count", tick_count, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmp("lit_init_cs", tmr_bus.chipselect, 1);
      cmp("lit_init_write", {tmr_bus.address, tmr_bus.writedata}, SEQ_RESET[k]);
    end
    cmp("lit_busy_ctrl", cfg_busy, 1);
    @(negedge clk);
    cmp("lit_busy_run", cfg_busy, 0);

    for (int k = 0; k < 3; k++) doTick(ev, av);
    cmp("lit_count3", tick_count, 3);

    applyStimulus(0, 32'd0, 4'b0100, '0, 16'd3, 0);
    applyStimulus(0, 32'd0, '0, '0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      doTick(ev, av);
      cmp("lit_ch2_expire", ev[2], (k == 2));
    end
    cmp("lit_ch2_active", av[2], 0);

    applyStimulus(1, 32'h0001_86A0, '0, '0, '0, 0);
    applyStimulus(0, 32'd0, '0, '0, '0, 0);
    collectWrites(5);
    for (int k = 0; k < 5; k++) cmp("lit_cfg_write", {col_a[k], col_d[k]}, SEQ_CFG[k]);
    @(negedge clk);
    cmp("lit_cfg_busy_done", cfg_busy, 0);

    applyStimulus(1, PERIOD_DEFAULT, '0, '0, '0, 1);
    applyStimulus(0, 32'd0, '0, '0, '0, 0);
    collectWrites(6);
    for (int k = 0; k < 6; k++) cmp("lit_both_write", {col_a[k], col_d[k]}, SEQ_BOTH[k]);
    cmp("lit_count7", tick_count, 7);

    applyStimulus(0, 32'd0, 4'b0010, '0, 16'd9, 0);
    applyStimulus(0, 32'd0, '0, '0, '0, 0);
    repeat (3) applyStimulus(0, 32'd0, '0, '0, '0, 0);
    applyStimulus(0, 32'd0, '0, '0, '0, 1);
    applyStimulus(0, 32'd0, 4'b0001, 4'b0010, 16'd5, 0);
    applyStimulus(0, 32'd0, '0, '0, '0, 0);
    @(negedge clk);
    cmp("lit_same_tick", tick_pulse, 1);
    cmp("lit_same_act",  ch_active[1:0], 2'b01);
    cmp("lit_same_exp",  ch_expire, 0);
    for (int k = 1; k <= 5; k++) begin
      doTick(ev, av);
      cmp("lit_ch0_expire", ev[0], (k == 5));
    end

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        ch_load   = '0;
        ch_cancel = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
      end else begin
        applyStimulus(($urandom_range(0, 99) == 0), $urandom,
                      ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom_range(0, 15)) : '0,
                      ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom_range(0, 15)) : '0,
                      CH_W'($urandom_range(0, 6)),
                      ($urandom_range(0, 5) == 0));
      end
    end
    repeat (20) applyStimulus(0, 32'd0, '0, '0, '0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
